// File: rtl/fir_out_capture.sv
// Captures FIR output samples into a 256x16 single-port memory after a warm-up discard.
// Define FIR_OUT_SAT_EN to clamp out-of-range samples instead of wrapping them.
module fir_out_capture #(
    parameter int IN_W    = 26,
    parameter int OUT_W   = 16,
    parameter int DISCARD = 7,
    parameter int DEPTH   = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             mem_nce,
    output logic             mem_nwrt,
    output logic [5:0]       mem_ra,
    output logic [1:0]       mem_ca,
    output logic [OUT_W-1:0] mem_din,
    output logic             busy,
    output logic             done,
    output logic [8:0]       ovf_cnt,
    output logic [15:0]      checksum
);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

    localparam int SH_W = IN_W - 7;
    localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] MIN_V = {{(SH_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t            state_reg, state_next;
    logic [7:0]        skip_cnt_reg;
    logic [8:0]        addr_reg;
    logic              nwrt_reg;
    logic [7:0]        wa_reg;
    logic [OUT_W-1:0]  din_reg;
    logic [8:0]        ovf_reg;
    logic [15:0]       sum_reg;

    logic signed [IN_W:0]   rounded;
    logic signed [SH_W-1:0] shifted;
    logic                   out_of_range;
    logic [OUT_W-1:0]       conv;
    logic                   accept;
    logic                   last_write;
    logic                   skip_last;
    logic                   run_start;

    // Sign-extend by one bit so the rounding add can never overflow.
    always_comb begin
        rounded      = {in_data[IN_W-1], in_data} + (IN_W+1)'(128);
        shifted      = SH_W'(rounded >>> 8);
        out_of_range = (shifted > MAX_V) || (shifted < MIN_V);
`ifdef FIR_OUT_SAT_EN
        if (out_of_range)
            conv = shifted[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
            conv = shifted[OUT_W-1:0];
`else
        conv = shifted[OUT_W-1:0];
`endif
    end

    // With no warm-up the single SKIP cycle already accepts samples.
    always_comb begin
        run_start  = start && (state_reg == IDLE || state_reg == DONE);
        accept     = in_valid && (state_reg == CAPTURE || (state_reg == SKIP && DISCARD == 0));
        last_write = accept && (addr_reg == 9'(DEPTH-1));
        skip_last  = (DISCARD == 0) ? 1'b1 : (in_valid && skip_cnt_reg == 8'(DISCARD-1));
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = SKIP;
            SKIP: begin
                if (last_write)
                    state_next = DONE;
                else if (skip_last)
                    state_next = CAPTURE;
            end
            CAPTURE: if (last_write) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            skip_cnt_reg <= '0;
            addr_reg     <= '0;
            nwrt_reg     <= 1'b1;
            wa_reg       <= '0;
            din_reg      <= '0;
            ovf_reg      <= '0;
            sum_reg      <= '0;
        end else begin
            nwrt_reg <= 1'b1;
            if (run_start) begin
                skip_cnt_reg <= '0;
                addr_reg     <= '0;
                ovf_reg      <= '0;
                sum_reg      <= '0;
            end
            if (state_reg == SKIP && in_valid && DISCARD != 0)
                skip_cnt_reg <= skip_cnt_reg + 8'd1;
            // The write is issued here and appears on the memory pins next cycle.
            if (accept) begin
                nwrt_reg <= 1'b0;
                wa_reg   <= addr_reg[7:0];
                din_reg  <= conv;
                addr_reg <= addr_reg + 9'd1;
                ovf_reg  <= ovf_reg + {8'd0, out_of_range};
                sum_reg  <= sum_reg + 16'(conv);
            end
        end
    end

    assign mem_nce  = nwrt_reg;
    assign mem_nwrt = nwrt_reg;
    assign mem_ra   = wa_reg[7:2];
    assign mem_ca   = wa_reg[1:0];
    assign mem_din  = din_reg;
    assign busy     = (state_reg == SKIP) || (state_reg == CAPTURE);
    assign done     = (state_reg == DONE);
    assign ovf_cnt  = ovf_reg;
    assign checksum = sum_reg;

endmodule

// File: tb/tb_fir_out_capture.sv
// Randomized bench for fir_out_capture against a sample-indexed reference model.
module tb_fir_out_capture;

    localparam int IN_W    = 26;
    localparam int OUT_W   = 16;
    localparam int DISCARD = 7;
    localparam int DEPTH   = 256;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             mem_nce, mem_nwrt;
    logic [5:0]       mem_ra;
    logic [1:0]       mem_ca;
    logic [OUT_W-1:0] mem_din;
    logic             busy, done;
    logic [8:0]       ovf_cnt;
    logic [15:0]      checksum;

    fir_out_capture #(.IN_W(IN_W), .OUT_W(OUT_W), .DISCARD(DISCARD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
        .mem_nce(mem_nce), .mem_nwrt(mem_nwrt), .mem_ra(mem_ra), .mem_ca(mem_ca),
        .mem_din(mem_din), .busy(busy), .done(done), .ovf_cnt(ovf_cnt), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: run progress expressed as sample counts.
    bit          running = 0;
    bit          done_m  = 0;
    int          nvalid  = 0;
    int          nwritten = 0;
    logic [15:0] exp_sum = '0;
    int          exp_ovf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_conv(input logic [IN_W-1:0] d, output bit ovf);
        int          sx;
        int          v;
        logic [31:0] vb;
        sx = $signed(d);
        v  = (sx + 128) >>> 8;
        vb = v;
        ovf = (v > 32767) || (v < -32768);
`ifdef FIR_OUT_SAT_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return vb[15:0];
    endfunction

    task automatic step(input bit st, input bit v, input logic [IN_W-1:0] d);
        bit          wr;
        bit          ovf;
        int          waddr;
        logic [31:0] wa;
        logic [15:0] wd;
        start = st; in_valid = v; in_data = d;
        @(posedge clk); #1;
        wr = 0; wd = '0; waddr = 0;
        if (running) begin
            if (v) begin
                if (nvalid >= DISCARD && nwritten < DEPTH) begin
                    wr = 1;
                    wd = ref_conv(d, ovf);
                    waddr = nwritten;
                    nwritten++;
                    exp_sum = exp_sum + wd;
                    exp_ovf = exp_ovf + int'(ovf);
                    if (nwritten == DEPTH) begin
                        running = 0;
                        done_m  = 1;
                    end
                end
                nvalid++;
            end
        end else if (st) begin
            running = 1; done_m = 0; nvalid = 0; nwritten = 0; exp_sum = '0; exp_ovf = 0;
        end
        check("mem_nwrt", {31'd0, mem_nwrt}, {31'd0, !wr});
        check("mem_nce", {31'd0, mem_nce}, {31'd0, !wr});
        if (wr) begin
            wa = waddr;
            $display("write addr=%0d data=%04h", waddr, wd);
            check("addr", {24'd0, mem_ra, mem_ca}, {24'd0, wa[7:0]});
            check("mem_din", {16'd0, mem_din}, {16'd0, wd});
        end
        check("busy", {31'd0, busy}, {31'd0, running});
        check("done", {31'd0, done}, {31'd0, done_m});
        check("ovf_cnt", {23'd0, ovf_cnt}, exp_ovf);
        check("checksum", {16'd0, checksum}, {16'd0, exp_sum});
    endtask

    task automatic reset_step(input bit st, input bit v);
        rstn = 1'b0; start = st; in_valid = v; in_data = '1;
        @(posedge clk); #1;
        running = 0; done_m = 0; nvalid = 0; nwritten = 0; exp_sum = '0; exp_ovf = 0;
        check("rst_nwrt", {31'd0, mem_nwrt}, 32'd1);
        check("rst_nce", {31'd0, mem_nce}, 32'd1);
        check("rst_addr", {24'd0, mem_ra, mem_ca}, 32'd0);
        check("rst_din", {16'd0, mem_din}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {23'd0, ovf_cnt}, 32'd0);
        check("rst_sum", {16'd0, checksum}, 32'd0);
        rstn = 1'b1;
    endtask

    function automatic logic [IN_W-1:0] rand_sample();
        int               s;
        logic [IN_W-1:0]  d;
        if ($urandom_range(0, 1) == 1) begin
            s = int'($urandom_range(0, 1 << 23)) - (1 << 22);
            d = s[IN_W-1:0];
        end else begin
            d = IN_W'($urandom);
        end
        return d;
    endfunction

    // Feed random samples until the run completes, with bounded cycle budget.
    task automatic finish_run(input bit toggle, input bit poke_start);
        int guard = 0;
        bit v = 0;
        while (running && guard < 5000) begin
            v = toggle ? !v : ($urandom_range(0, 3) != 0);
            step(poke_start && ($urandom_range(0, 15) == 0), v, rand_sample());
            guard++;
        end
        check("run_timeout", {31'd0, running}, 32'd0);
    endtask

    initial begin
        logic [IN_W-1:0] d;
        int guard;
        reset_step(0, 0);
        reset_step(1, 1);

        // Ramp: k<<8 for 263 samples lands data 7..262 at addresses 0..255.
        step(1, 0, '0);
        for (int k = 0; k < 263; k++) begin
            d = IN_W'(k << 8);
            step(0, 1, d);
        end
        step(0, 0, '0);
        check("ramp_done", {31'd0, done}, 32'd1);
        check("ramp_ovf", {23'd0, ovf_cnt}, 32'd0);

        // Rounding and range edges, then random with start pokes mid-capture.
        step(1, 0, '0);
        for (int k = 0; k < DISCARD; k++) step(0, 1, '0);
        step(0, 1, IN_W'(32'h0000080));
        step(0, 1, IN_W'(32'h000007F));
        d = IN_W'(32'h1FFFFFF >> 1);
        step(0, 1, d);
        check("max_pos_ovf", {23'd0, ovf_cnt}, 32'd1);
        step(0, 1, IN_W'(32'h3000000));
        step(0, 1, IN_W'(32'h3FFFF80));
        step(1, 1, IN_W'(32'h07FFF7F));
        finish_run(0, 1);
        step(0, 0, '0);
        check("rand_done", {31'd0, done}, 32'd1);

        // Abort after the 100th write, then a toggled-valid run from address 0.
        step(1, 0, '0);
        guard = 0;
        while (nwritten < 100 && guard < 1000) begin
            step(0, 1, rand_sample());
            guard++;
        end
        check("pre_abort_cnt", nwritten, 32'd100);
        reset_step(1, 1);
        step(0, 1, rand_sample());
        step(1, 0, '0);
        finish_run(1, 0);
        step(0, 0, '0);
        step(1, 0, '0);
        finish_run(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
